// File: rtl/flame_pkg.sv
// Shared definitions for the flame alarm controller.
//   state_e   : per-channel alarm state encoding
//   cnt_width : bit width of a counter that runs 0..n-1 (never less than 1)
package flame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flame_debounce.sv
// One sensor channel: two-flop synchroniser followed by a debounce counter.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   din      : raw active-low sensor output (asynchronous)
//   flame    : debounced flame indication (1 = flame present)
// The synchroniser and the accepted level reset to 1 (no flame), so leaving
// reset never produces a spurious alarm.
module flame_debounce
    import flame_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic flame
);

    localparam int CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // The counter only runs while the synchronised input disagrees with
        // the accepted level; any agreeing sample restarts the count, so a
        // new level must be seen on DB_CYCLES consecutive edges.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flame = ~level_q;

endmodule

// File: rtl/flame_alarm_ctrl.sv
// Multi-channel flame-sensor front end driving LEDs and a buzzer.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   do_in     : raw active-low sensor outputs, one per channel
//   mask      : 1 forces a channel to IDLE
//   ack       : one-cycle pulse, clears every HOLD channel
//   led       : per-channel indicator, steady in ACTIVE, blinking in HOLD
//   alarm     : any channel in ACTIVE or HOLD
//   alarm_ch  : lowest ACTIVE channel, else lowest HOLD channel, else 0
//   evt_cnt   : saturating count of cycles with at least one alarm onset
// All outputs are registered and change on the same edge as channel state.
module flame_alarm_ctrl
    import flame_pkg::*;
#(
    parameter int CH         = 4,
    parameter int DB_CYCLES  = 500000,
    parameter int BLINK_HALF = 12500000,
    parameter int LATCH      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] do_in,
    input  logic [CH-1:0] mask,
    input  logic          ack,
    output logic [CH-1:0] led,
    output logic          alarm,
    output logic [3:0]    alarm_ch,
    output logic [7:0]    evt_cnt
);

    localparam int BL_W = cnt_width(BLINK_HALF);
    localparam logic [BL_W-1:0] BLINK_MAX = BL_W'(BLINK_HALF - 1);

    logic [CH-1:0] flame;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        flame_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .din   (do_in[g]),
            .flame (flame[g])
        );
    end

    state_e          state_q [CH];
    state_e          state_d [CH];
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic [CH-1:0]   led_q, led_d;
    logic            alarm_q, alarm_d;
    logic [3:0]      alarm_ch_q, alarm_ch_d;
    logic [7:0]      evt_cnt_q, evt_cnt_d;
    logic            onset;
    logic            any_act, any_hold;
    logic [3:0]      act_idx, hold_idx;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BL_W'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        onset    = 1'b0;
        led_d    = '0;
        any_act  = 1'b0;
        any_hold = 1'b0;
        act_idx  = 4'd0;
        hold_idx = 4'd0;

        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE:   if (flame[i]) state_d[i] = ST_ACTIVE;
                ST_ACTIVE: if (!flame[i]) state_d[i] = (LATCH != 0) ? ST_HOLD : ST_IDLE;
                // A re-ignition beats a simultaneous acknowledge.
                ST_HOLD: begin
                    if (flame[i])   state_d[i] = ST_ACTIVE;
                    else if (ack)   state_d[i] = ST_IDLE;
                end
                default:   state_d[i] = ST_IDLE;
            endcase
            if (mask[i]) state_d[i] = ST_IDLE;

            if (state_d[i] == ST_ACTIVE && state_q[i] != ST_ACTIVE) onset = 1'b1;
            led_d[i] = (state_d[i] == ST_ACTIVE) | ((state_d[i] == ST_HOLD) & phase_d);
        end

        // Scan downwards so the lowest-numbered channel is the one kept.
        for (int i = CH - 1; i >= 0; i--) begin
            if (state_d[i] == ST_ACTIVE) begin
                any_act = 1'b1;
                act_idx = 4'(i);
            end
            if (state_d[i] == ST_HOLD) begin
                any_hold = 1'b1;
                hold_idx = 4'(i);
            end
        end

        alarm_d    = any_act | any_hold;
        alarm_ch_d = any_act ? act_idx : (any_hold ? hold_idx : 4'd0);
        evt_cnt_d  = (onset && evt_cnt_q != 8'hFF) ? evt_cnt_q + 8'd1 : evt_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) state_q[i] <= ST_IDLE;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            led_q       <= '0;
            alarm_q     <= 1'b0;
            alarm_ch_q  <= 4'd0;
            evt_cnt_q   <= 8'd0;
        end else begin
            for (int i = 0; i < CH; i++) state_q[i] <= state_d[i];
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            alarm_q     <= alarm_d;
            alarm_ch_q  <= alarm_ch_d;
            evt_cnt_q   <= evt_cnt_d;
        end
    end

    assign led      = led_q;
    assign alarm    = alarm_q;
    assign alarm_ch = alarm_ch_q;
    assign evt_cnt  = evt_cnt_q;

endmodule
